// File: rtl/parity_link_pkg.sv
// Definitions shared by both ends of the parity-protected serial link.
// The receiver imports parity_of from here, so generation and check use the same rule.
package parity_link_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } link_state_e;

  localparam logic START_LVL = 1'b0;
  localparam logic STOP_LVL  = 1'b1;
  localparam logic IDLE_LVL  = 1'b1;

  // Callers zero-extend narrower words; the extra zeros leave the XOR unchanged.
  function automatic logic parity_of(input logic [15:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/parity_tx_baud.sv
// Bit-period counter: bit_tick is high in the last cycle of every serial bit.
// tick_ahead predicts next cycle's bit_tick so the parent can register its own outputs.
module parity_tx_baud #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic bit_tick,
  output logic tick_ahead
);

  localparam logic [15:0] LAST = 16'(CLKS_PER_BIT - 1);

  logic [15:0] cnt_reg;
  logic [15:0] cnt_next;
  logic        tick_reg;

  always_comb begin
    cnt_next = cnt_reg + 16'd1;
    if (restart || cnt_reg == LAST) begin
      cnt_next = 16'd0;
    end
  end

  assign tick_ahead = (cnt_next == LAST);
  assign bit_tick   = tick_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg  <= 16'd0;
      tick_reg <= (LAST == 16'd0);
    end else begin
      cnt_reg  <= cnt_next;
      tick_reg <= tick_ahead;
    end
  end

endmodule

// File: rtl/parity_frame_tx.sv
// Parity-protected serial frame transmitter: start, DATA_W data bits LSB first,
// parity, stop. Every output is a flop loaded from the next-state values.
module parity_frame_tx
  import parity_link_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4,
  parameter int PARITY_ODD   = 0,
  parameter int DATA_W       = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              tx_line,
  output logic              busy,
  output logic              frame_done,
  output logic              parity_out
);

  localparam logic [4:0] LAST_BIT = 5'(DATA_W - 1);

  link_state_e       state_reg;
  link_state_e       state_next;
  logic [DATA_W-1:0] shift_reg;
  logic [DATA_W-1:0] shift_next;
  logic [4:0]        bit_cnt_reg;
  logic [4:0]        bit_cnt_next;
  logic              parity_reg;
  logic              parity_next;
  logic              tx_reg;
  logic              tx_next;
  logic              done_reg;
  logic              done_next;
  logic              ready_reg;
  logic              busy_reg;
  logic              accept;
  logic              bit_tick;
  logic              tick_ahead;

  assign accept = in_valid & ready_reg;

  parity_tx_baud #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk       (clk),
    .rst_n     (rst_n),
    .restart   (accept),
    .bit_tick  (bit_tick),
    .tick_ahead(tick_ahead)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      shift_reg   <= '0;
      bit_cnt_reg <= 5'd0;
      parity_reg  <= 1'b0;
      tx_reg      <= IDLE_LVL;
      done_reg    <= 1'b0;
      ready_reg   <= 1'b1;
      busy_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      shift_reg   <= shift_next;
      bit_cnt_reg <= bit_cnt_next;
      parity_reg  <= parity_next;
      tx_reg      <= tx_next;
      done_reg    <= done_next;
      ready_reg   <= (state_next == IDLE);
      busy_reg    <= (state_next != IDLE);
    end
  end

  always_comb begin
    state_next   = state_reg;
    shift_next   = shift_reg;
    bit_cnt_next = bit_cnt_reg;
    parity_next  = parity_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          state_next   = START;
          shift_next   = in_data;
          bit_cnt_next = 5'd0;
          parity_next  = parity_of(16'(in_data), PARITY_ODD != 0);
        end
      end
      START: begin
        if (bit_tick) state_next = DATA;
      end
      DATA: begin
        if (bit_tick) begin
          shift_next = shift_reg >> 1;
          if (bit_cnt_reg == LAST_BIT) begin
            state_next   = PARITY;
            bit_cnt_next = 5'd0;
          end else begin
            bit_cnt_next = bit_cnt_reg + 5'd1;
          end
        end
      end
      PARITY: begin
        if (bit_tick) state_next = STOP;
      end
      STOP: begin
        if (bit_tick) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Line level and done pulse are decoded from the upcoming state, then registered.
  always_comb begin
    tx_next   = IDLE_LVL;
    done_next = 1'b0;
    case (state_next)
      START:   tx_next = START_LVL;
      DATA:    tx_next = shift_next[0];
      PARITY:  tx_next = parity_next;
      STOP: begin
        tx_next   = STOP_LVL;
        done_next = tick_ahead;
      end
      default: tx_next = IDLE_LVL;
    endcase
  end

  assign tx_line    = tx_reg;
  assign frame_done = done_reg;
  assign in_ready   = ready_reg;
  assign busy       = busy_reg;
  assign parity_out = parity_reg;

endmodule

// File: tb/tb_parity_frame_tx.sv
// Bench for parity_frame_tx: two instances (4 clk/bit even parity, 1 clk/bit odd parity)
// checked every cycle against a frame-position model, plus directed literal checks.
module tb_parity_frame_tx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       vin  [2] = '{1'b0, 1'b0};
  logic [7:0] din  [2] = '{8'h00, 8'h00};
  logic       rdy  [2];
  logic       tx   [2];
  logic       bsy  [2];
  logic       done [2];
  logic       par  [2];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  parity_frame_tx #(.CLKS_PER_BIT(4), .PARITY_ODD(0), .DATA_W(8)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_data(din[0]), .in_valid(vin[0]),
    .in_ready(rdy[0]), .tx_line(tx[0]), .busy(bsy[0]),
    .frame_done(done[0]), .parity_out(par[0])
  );

  parity_frame_tx #(.CLKS_PER_BIT(1), .PARITY_ODD(1), .DATA_W(8)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_data(din[1]), .in_valid(vin[1]),
    .in_ready(rdy[1]), .tx_line(tx[1]), .busy(bsy[1]),
    .frame_done(done[1]), .parity_out(par[1])
  );

  // Model: each instance is either idle or at cycle 'pos' of a frame of len cycles.
  function automatic int cpb_of(input int d);
    return (d == 0) ? 4 : 1;
  endfunction

  function automatic logic odd_of(input int d);
    return (d == 0) ? 1'b0 : 1'b1;
  endfunction

  logic       m_act [2] = '{1'b0, 1'b0};
  int         m_pos [2] = '{0, 0};
  logic [7:0] m_dat [2] = '{8'h00, 8'h00};
  logic       m_par [2] = '{1'b0, 1'b0};

  always @(posedge clk or negedge rst_n) begin
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        m_act[d] <= 1'b0;
        m_pos[d] <= 0;
        m_par[d] <= 1'b0;
      end else if (m_act[d]) begin
        if (m_pos[d] == 11 * cpb_of(d) - 1) m_act[d] <= 1'b0;
        else m_pos[d] <= m_pos[d] + 1;
      end else if (vin[d]) begin
        m_act[d] <= 1'b1;
        m_pos[d] <= 0;
        m_dat[d] <= din[d];
        m_par[d] <= (^din[d]) ^ odd_of(d);
      end
    end
  end

  function automatic logic exp_tx(input int d);
    int idx;
    if (!m_act[d]) return 1'b1;
    idx = m_pos[d] / cpb_of(d);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return m_dat[d][idx-1];
    if (idx == 9) return m_par[d];
    return 1'b1;
  endfunction

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      logic [4:0] act_v;
      logic [4:0] exp_v;
      act_v = {tx[d], bsy[d], rdy[d], done[d], par[d]};
      exp_v = {exp_tx(d), m_act[d], !m_act[d],
               m_act[d] && (m_pos[d] == 11 * cpb_of(d) - 1), m_par[d]};
      tests++;
      if (act_v !== exp_v) begin
        fails++;
        $display("FAIL model_dut%0d t=%0t {tx,busy,ready,done,par} got=%b want=%b",
                 d, $time, act_v, exp_v);
      end
    end
  end

  task automatic check(input string name, input int got, input int want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end else begin
      $display("[TB] ok %s = %0d", name, got);
    end
  endtask

  // Returns in cycle 1 of the frame (first start-bit cycle), 2 time units after the accept edge.
  task automatic send(input int d, input logic [7:0] data);
    int ok;
    ok = 0;
    vin[d] = 1'b1;
    din[d] = data;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (rdy[d]) begin
        ok = 1;
        break;
      end
    end
    @(posedge clk);
    #2;
    vin[d] = 1'b0;
    if (ok == 0) check("send_timeout", 0, 1);
    $display("[TB] dut%0d sent 0x%02h", d, data);
  endtask

  task automatic wait_idle(input int d);
    int ok;
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (rdy[d]) begin
        ok = 1;
        break;
      end
    end
    if (ok == 0) check("idle_timeout", 0, 1);
    @(posedge clk);
    #2;
  endtask

  // Captures 44 cycles of dut0 and compares with a literal frame pattern.
  task automatic frame_literal(input string name, input logic [10:0] pat);
    int errs;
    int done_cyc;
    errs = 0;
    done_cyc = -1;
    for (int c = 1; c <= 44; c++) begin
      @(negedge clk);
      if (tx[0] !== pat[(c - 1) / 4]) errs++;
      if (done[0] === 1'b1 && done_cyc < 0) done_cyc = c;
    end
    check({name, "_pattern_errs"}, errs, 0);
    check({name, "_done_cycle"}, done_cyc, 44);
    @(negedge clk);
    check({name, "_ready_c45"}, int'(rdy[0]), 1);
  endtask

  initial begin
    int errs;
    int dcyc;
    logic [10:0] pat;

    // Reset
    repeat (2) @(posedge clk);
    #2;
    check("rst_tx", int'(tx[0]), 1);
    check("rst_ready", int'(rdy[0]), 1);
    check("rst_busy", int'(bsy[0]), 0);
    check("rst_done", int'(done[0]), 0);
    check("rst_parity", int'(par[0]), 0);
    rst_n = 1'b1;
    errs = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if ({tx[0], rdy[0], bsy[0], done[0], par[0]} !== 5'b11000) errs++;
    end
    check("idle_hold_errs", errs, 0);
    @(posedge clk);
    #2;

    // 0xA5, even parity: 0, 1,0,1,0,0,1,0,1, 0, 1
    send(0, 8'hA5);
    pat = {1'b1, 1'b0, 8'hA5, 1'b0};
    check("a5_parity_out", int'(par[0]), 0);
    frame_literal("a5", pat);
    wait_idle(0);

    // 0x01: even parity bit 1 on dut0, odd parity bit 0 on dut1
    send(0, 8'h01);
    check("even_01_parity_out", int'(par[0]), 1);
    wait_idle(0);
    send(1, 8'h01);
    check("odd_01_parity_out", int'(par[1]), 0);
    for (int c = 2; c <= 10; c++) @(negedge clk);
    check("odd_01_parity_bit", int'(tx[1]), 0);
    wait_idle(1);

    // Back-to-back 0xFF then 0x00 with in_valid held high
    vin[0] = 1'b1;
    din[0] = 8'hFF;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (rdy[0]) break;
    end
    @(posedge clk);
    #2;
    din[0] = 8'h00;
    $display("[TB] dut0 sent 0xff (b2b)");
    check("b2b_ff_parity", int'(par[0]), 0);
    dcyc = -1;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      if (done[0] === 1'b1) begin
        dcyc = c;
        break;
      end
    end
    check("b2b_done_cycle", dcyc, 44);
    @(negedge clk);
    check("b2b_gap_ready", int'(rdy[0]), 1);
    check("b2b_gap_idle_high", int'(tx[0]), 1);
    @(posedge clk);
    #2;
    vin[0] = 1'b0;
    $display("[TB] dut0 sent 0x00 (b2b)");
    @(negedge clk);
    check("b2b_second_start", int'(tx[0]), 0);
    check("b2b_second_busy", int'(bsy[0]), 1);
    check("b2b_00_parity", int'(par[0]), 0);
    wait_idle(0);

    // in_valid pulsed mid-frame is ignored
    send(0, 8'h07);
    repeat (10) @(posedge clk);
    #2;
    vin[0] = 1'b1;
    din[0] = 8'h3C;
    @(posedge clk);
    #2;
    vin[0] = 1'b0;
    check("ignore_parity_kept", int'(par[0]), 1);
    wait_idle(0);
    @(negedge clk);
    check("ignore_no_extra_accept", int'(bsy[0]), 0);
    @(posedge clk);
    #2;

    // Reset asserted at cycle 17 of a 0x5A frame
    send(0, 8'h5A);
    repeat (16) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_tx", int'(tx[0]), 1);
    check("midrst_busy", int'(bsy[0]), 0);
    check("midrst_done", int'(done[0]), 0);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #2;
    send(0, 8'h5A);
    pat = {1'b1, 1'b0, 8'h5A, 1'b0};
    frame_literal("5a_after_rst", pat);
    wait_idle(0);

    // Randomised traffic on both instances
    for (int i = 0; i < 600; i++) begin
      vin[0] = ($urandom_range(0, 3) == 0);
      vin[1] = ($urandom_range(0, 1) == 0);
      din[0] = 8'($urandom);
      din[1] = 8'($urandom);
      @(posedge clk);
      #2;
    end
    vin[0] = 1'b0;
    vin[1] = 1'b0;
    wait_idle(0);
    wait_idle(1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
